// File: rtl/wb_grf_commit.sv
// wb_grf_commit: W pipeline register, 32x32 GRF with same-cycle write bypass,
// and a 4-deep commit-trace FIFO with sticky overflow plus a retire counter.
module wb_grf_commit (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [5:0]  m_op,
    input  logic [5:0]  m_fuc,
    input  logic [4:0]  m_a3,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_dm,
    input  logic [31:0] m_pc,
    input  logic        w_en,
    input  logic        w_flush,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic        fwd_we,
    output logic [4:0]  fwd_a3,
    output logic [31:0] fwd_wd,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_wd,
    output logic [4:0]  trace_a3,
    output logic        trace_overflow,
    output logic [15:0] retire_cnt
);
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDEI = 6'b110011;
    localparam logic [5:0] FUC_ADD  = 6'b100000;
    localparam logic [5:0] FUC_SUB  = 6'b100010;

    logic        w_valid_q;
    logic [5:0]  w_op_q, w_fuc_q;
    logic [4:0]  w_a3_q;
    logic [31:0] w_alu_q, w_dm_q, w_pc_q;
    logic [31:0] grf_q [32];
    logic [68:0] fifo_q [4];
    logic [1:0]  rd_ptr_q, wr_ptr_q;
    logic [2:0]  cnt_q, cnt_d;
    logic        ovf_q;
    logic [15:0] retire_q, retire_d;
    logic        dec_we, push, pop;

    always_comb begin
        dec_we = (w_op_q == OP_R) ? (w_fuc_q == FUC_ADD || w_fuc_q == FUC_SUB)
                                  : (w_op_q inside {OP_ORI, OP_LW, OP_LUI, OP_JAL, OP_ADDEI});
        fwd_we = w_valid_q && dec_we && (w_a3_q != 5'd0);
        fwd_a3 = w_a3_q;
        fwd_wd = (w_op_q == OP_LW) ? w_dm_q : (w_op_q == OP_JAL) ? w_pc_q + 32'd8 : w_alu_q;
        rd1 = (fwd_we && a1 == fwd_a3) ? fwd_wd : grf_q[a1];
        rd2 = (fwd_we && a2 == fwd_a3) ? fwd_wd : grf_q[a2];
        trace_valid = cnt_q != 3'd0;
        pop = trace_valid && trace_ready;
        // a full FIFO still accepts a push when the head leaves on the same edge
        push = fwd_we && (cnt_q != 3'd4 || pop);
        cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
        retire_d = (w_valid_q && (w_en || w_flush)) ? retire_q + 16'd1 : retire_q;
        {trace_pc, trace_a3, trace_wd} = fifo_q[rd_ptr_q];
        trace_overflow = ovf_q;
        retire_cnt = retire_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_valid_q <= 1'b0;
            w_op_q    <= '0;
            w_fuc_q   <= '0;
            w_a3_q    <= '0;
            w_alu_q   <= '0;
            w_dm_q    <= '0;
            w_pc_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            retire_q  <= '0;
            for (int i = 0; i < 32; i++) grf_q[i] <= '0;
        end else begin
            if (w_flush) begin
                w_valid_q <= 1'b0;
            end else if (w_en) begin
                w_valid_q <= m_valid;
                w_op_q    <= m_op;
                w_fuc_q   <= m_fuc;
                w_a3_q    <= m_a3;
                w_alu_q   <= m_alu;
                w_dm_q    <= m_dm;
                w_pc_q    <= m_pc;
            end
            if (fwd_we) grf_q[fwd_a3] <= fwd_wd;
            if (push) begin
                fifo_q[wr_ptr_q] <= {w_pc_q, fwd_a3, fwd_wd};
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            if (fwd_we && !push) ovf_q <= 1'b1;
            cnt_q    <= cnt_d;
            retire_q <= retire_d;
        end
    end
endmodule

// File: doc/wb_grf_commit.md
WB_GRF_COMMIT -- requirements
Module: wb_grf_commit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-low; sampled on rising clk edge.
REQ-003 m_valid  in  1  M stage holds a real instruction (0 = bubble).
REQ-004 m_op, m_fuc  in  6 each  instruction opcode / funct from M stage.
REQ-005 m_a3  in  5  destination register index.
REQ-006 m_alu, m_dm, m_pc  in  32 each  ALU result, DM read data, instruction PC.
REQ-007 w_en  in  1  1 = load W register from M inputs this edge; 0 = hold.
REQ-008 w_flush  in  1  1 = load bubble into W register; dominates w_en.
REQ-009 a1, a2  in  5 each  read addresses; rd1, rd2  out  32 each  read data.
REQ-010 fwd_we  out  1, fwd_a3  out  5, fwd_wd  out  32  W-stage write visible to hazard/forwarding logic.
REQ-011 trace_valid  out  1, trace_ready  in  1, trace_pc / trace_wd  out  32, trace_a3  out  5  commit-trace handshake.
REQ-012 trace_overflow  out  1  sticky; a trace entry was dropped.
REQ-013 retire_cnt  out  16  count of retired W-stage instructions.

Function
REQ-014 W register (valid, op, fuc, a3, alu, dm, pc) SHALL load on edge: w_flush=1 -> valid=0; else w_en=1 -> M inputs; else hold.
REQ-015 Write-enable decode SHALL assert for: op 000000 with fuc 100000 (add) or 100010 (sub); op 001101 (ori), 100011 (lw), 001111 (lui), 000011 (jal), 110011 (addei); all others (sw 101011, beq 000100, jr fuc 001000, unknown) SHALL not write.
REQ-016 fwd_we SHALL = W.valid & decoded write-enable & (W.a3 != 0); fwd_a3 = W.a3.
REQ-017 fwd_wd SHALL = W.dm for lw, W.pc+8 (mod 2^32) for jal, else W.alu.
REQ-018 GRF (32x32) SHALL write fwd_wd to entry fwd_a3 at the rising edge ending the cycle fwd_we=1; latency M-sample to GRF update = 2 edges.
REQ-019 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded.
REQ-020 rd1/rd2 SHALL be combinational; if fwd_we=1 and address == fwd_a3, rd SHALL return fwd_wd (same-cycle write bypass), else GRF content.
REQ-021 Trace FIFO: 4 entries, entry = {pc, a3, wd}; push on edge where fwd_we=1; pop on edge where trace_valid & trace_ready; trace_valid = not empty; outputs show head entry.
REQ-022 Push when full without simultaneous pop SHALL drop the entry and set trace_overflow; simultaneous push+pop when full SHALL succeed (no overflow, count stays 4).
REQ-023 Pop when empty SHALL be ignored; FIFO pointers SHALL wrap modulo 4.
REQ-024 trace_overflow SHALL remain 1 until reset; trace path SHALL never stall or alter GRF writes.
REQ-025 retire_cnt SHALL increment by 1 on each edge where W.valid=1 and the W register is being replaced (w_en=1 or w_flush=1), including non-writing instructions; wraps 0xFFFF -> 0x0000.
REQ-026 W.valid=1 with w_en=0 and w_flush=0 (stall) SHALL not re-count retirement; the GRF write SHALL repeat each held cycle with identical data (idempotent).

Reset
REQ-027 reset=0 at an edge SHALL clear: W.valid, all 32 GRF entries, FIFO (empty, trace_valid=0), trace_overflow, retire_cnt; reset dominates w_en, w_flush, trace_ready.
REQ-028 Reset asserted mid-operation SHALL cancel the in-flight W write at that edge (GRF ends all-zero).

Verification
REQ-029 M: add, a3=5, alu=0x1234, w_en=1 -> next cycle fwd_we=1, fwd_wd=0x1234, rd1 with a1=5 = 0x1234 same cycle; after following edge GRF[5]=0x1234.
REQ-030 jal, pc=0x00003000, a3=31 -> fwd_wd=0x00003008; lw, dm=0xDEADBEEF, a3=8 -> GRF[8]=0xDEADBEEF; sw/beq/jr -> fwd_we=0, retire_cnt still +1.
REQ-031 ori with a3=0, alu=0xFFFF -> fwd_we=0, rd1(a1=0)=0, no trace push.
REQ-032 trace_ready=0, 5 consecutive writes -> trace_valid=1, 4 entries held, trace_overflow=1; then trace_ready=1 -> first 4 entries pop in order, trace_valid drops.
REQ-033 FIFO full, trace_ready=1 and write in same cycle -> overflow stays 0, new entry appended last.
REQ-034 retire_cnt preloaded to 0xFFFF via 65535 retirements, one more -> 0x0000; reset=0 during a pending add write -> GRF[a3]=0, all outputs at reset values.
